// File: rtl/fas_pkg.sv
// ============================================================================
// Module  : fas_pkg
// Purpose : Shared constants, sample type and transmitter state encoding for
//           the FAS sample-stream transmitter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fas_pkg;

  // Samples per FFT frame.
  localparam int FAS_FRAME    = 16;
  // Width of one signed sample.
  localparam int FAS_SAMPLE_W = 16;

  typedef logic signed [FAS_SAMPLE_W-1:0] fas_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } fas_state_t;

endpackage

`default_nettype wire

// File: rtl/fas_sample_tx_if.sv
// ============================================================================
// Module  : fas_sample_tx_if
// Purpose : Bundles the host write port and the FIR-facing sample port of the
//           FAS sample transmitter.
// Ports   : in_valid/in_ready/in_data - host write handshake
//           enable                    - permits new frames
//           data_valid/data           - sample stream toward FIR
//           frame_done                - last-sample-of-frame pulse
//           level                     - FIFO occupancy
//           busy                      - transmitter not idle
//           modport master : host side, modport slave : transmitter side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fas_sample_tx_if #(
  parameter int DEPTH = 32
) ();
  import fas_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  fas_sample_t       in_data;
  logic              enable;
  logic              data_valid;
  fas_sample_t       data;
  logic              frame_done;
  logic [LVL_W-1:0]  level;
  logic              busy;

  modport master (
    output in_valid, in_data, enable,
    input  in_ready, data_valid, data, frame_done, level, busy
  );

  modport slave (
    input  in_valid, in_data, enable,
    output in_ready, data_valid, data, frame_done, level, busy
  );

endinterface

`default_nettype wire

// File: rtl/fas_sample_fifo.sv
// ============================================================================
// Module  : fas_sample_fifo
// Purpose : Synchronous sample FIFO with registered occupancy count.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-low reset
//           i_push  - write i_data (ignored when full)
//           i_pop   - advance read pointer (ignored when empty)
//           i_data  - sample to write
//           o_head  - sample at the read pointer
//           o_level - current occupancy, 0..DEPTH
//           o_full  - occupancy equals DEPTH
//           o_empty - occupancy is zero
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fas_sample_fifo
  import fas_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire fas_sample_t                i_data,
  output fas_sample_t                     o_head,
  output logic [$clog2(DEPTH):0]          o_level,
  output logic                            o_full,
  output logic                            o_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_DEPTH_LVL = c_LW'(DEPTH);

  fas_sample_t       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_LW-1:0]   r_level;

  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == c_DEPTH_LVL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop  && !o_empty;

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/fas_sample_tx.sv
// ============================================================================
// Module  : fas_sample_tx
// Purpose : Buffers host samples and releases them toward the FIR in
//           contiguous frames of FRAME samples, with GAP idle cycles
//           inserted after each frame.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-low reset
//           bus - fas_sample_tx_if.slave (host write port, FIR sample
//                 port, enable, frame_done, level, busy)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fas_sample_tx
  import fas_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int FRAME = FAS_FRAME,
  parameter int GAP   = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fas_sample_tx_if.slave  bus
);

  localparam int c_LW = $clog2(DEPTH) + 1;
  localparam int c_CW = $clog2(FRAME + 1);
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [c_LW-1:0] c_FRAME_LVL = c_LW'(FRAME);
  localparam logic [c_CW-1:0] c_FRAME_CNT = c_CW'(FRAME);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((GAP > 0) ? (GAP - 1) : 0);

  fas_state_t        r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt,   w_cnt_nxt;
  logic [c_GW-1:0]   r_gap,   w_gap_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_done,  w_done_nxt;
  fas_sample_t       r_data;

  logic              w_pop;
  logic              w_push;
  logic              w_start;
  logic              w_full;
  logic              w_empty;
  fas_sample_t       w_head;
  logic [c_LW-1:0]   w_level;

  assign w_push = bus.in_valid && !w_full;

  fas_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.in_data),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A frame only starts with a full frame already buffered, so SEND can
  // never underrun.
  assign w_start = bus.enable && (w_level >= c_FRAME_LVL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_pop) begin
        r_data <= w_head;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_pop       = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = c_CNT_ONE;
          w_done_nxt  = (c_FRAME_CNT == c_CNT_ONE);
          w_state_nxt = ST_SEND;
        end
      end

      ST_SEND: begin
        if (r_cnt < c_FRAME_CNT) begin
          w_pop       = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_done_nxt  = ((r_cnt + 1'b1) == c_FRAME_CNT);
        end else if (GAP > 0) begin
          w_gap_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (w_start) begin
          // Back-to-back frame: no idle cycle between frames.
          w_pop       = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = c_CNT_ONE;
          w_done_nxt  = (c_FRAME_CNT == c_CNT_ONE);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = !w_full;
  assign bus.data_valid = r_valid;
  assign bus.data       = r_data;
  assign bus.frame_done = r_done;
  assign bus.level      = w_level;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/fas_sample_tx.md
Name: fas_sample_tx

Overview:
Sample-stream transmitter that drives the FAS sample input (data_valid/data) toward the FIR.
- A host or testbench writes signed 16-bit samples through a valid/ready port into an internal FIFO.
- The block releases them in contiguous frames of FRAME samples, one per clock, with a programmable idle gap between frames.
- It is the producing end of the data_valid/data interface that FAS consumes.

Parameters:
DEPTH, 32, FIFO entries (power of 2, must be at least FRAME)
FRAME, 16, samples per burst; matches the 16-point FFT frame
GAP, 0, idle cycles inserted after each frame (0 = back-to-back frames allowed)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  host sample valid
in_ready  output  1  FIFO can accept a sample
in_data  input  16  signed host sample
enable  input  1  level; permits starting new frames
data_valid  output  1  sample strobe toward FIR
data  output  16  signed sample toward FIR
frame_done  output  1  one-cycle pulse on the last sample of a frame
level  output  $clog2(DEPTH)+1  current FIFO occupancy
busy  output  1  state is not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; level=0.
  - State=IDLE.
  - data_valid=0, data=0, frame_done=0, busy=0.
  - in_ready goes to 1 after reset release.
- Write side:
  - Push occurs when in_valid && in_ready.
  - in_ready = (level < DEPTH); it is derived from registered level only and ignores a same-cycle pop.
  - A push and a pop in the same cycle leave level unchanged.
  - A push while full is impossible by handshake; in_data is ignored whenever in_ready is low.
- FSM states: IDLE, SEND, GAP.
  - IDLE -> SEND when enable && level >= FRAME, sampled at a clock edge.
  - On that same edge:
    - head sample popped into data; data_valid<=1; cnt<=1.
    - data_valid is therefore high in the cycle following the condition (one-cycle latency).
  - SEND: on each edge with cnt < FRAME:
    - pop the next sample; data_valid stays 1; cnt++.
    - A frame is therefore exactly FRAME consecutive data_valid cycles with no bubbles.
    - Because a frame only starts once level >= FRAME, underrun is impossible.
  - frame_done=1 exactly in the cycle carrying sample FRAME, registered alongside data_valid.
  - SEND exit, on the edge ending the last sample:
    - If GAP>0: data_valid<=0, go to GAP, gap counter<=0.
    - If GAP=0: re-evaluate the start condition on that same edge. If true, pop immediately and remain in SEND with cnt<=1 (back-to-back frame, no idle cycle); otherwise go to IDLE with data_valid<=0.
  - GAP: data_valid=0 for exactly GAP cycles, then go to IDLE, which evaluates the start condition on its next edge.
- data holds its last value when data_valid=0 and is not required to be zero.
- enable low during SEND or GAP: the current frame and gap complete normally; no new frame starts.
- Samples are output in write order. Pointers wrap modulo DEPTH.
- Reset asserted mid-frame: outputs clear immediately (asynchronous) and the partial frame is discarded; no resume after reset release.
- busy=1 in SEND and GAP.

Decomposition:
- Shared package fas_pkg:
  - FAS_FRAME=16
  - sample width constant 16
  - state encoding IDLE/SEND/GAP
- One sub-module, fas_sample_fifo: synchronous FIFO with push, pop, head data, level, full/empty, async active-low reset.
- The FSM, counters and output registers stay in fas_sample_tx.

Test Plan:
1. Reset check: assert rst low mid-simulation -> in the same cycle data_valid=0, frame_done=0, level=0, busy=0; after release, in_ready=1.
2. Single frame: enable=1, push samples 1..16 -> data_valid high for exactly 16 consecutive cycles carrying 1..16 in order; frame_done only on the 16 cycle; level returns to 0; busy falls after the frame.
3. Insufficient data: push 15 samples with enable=1 -> data_valid never rises. Push the 16th -> data_valid rises on the second edge after that push (level reaches 16 on the first edge, the start condition is sampled and popped on the next), carrying value 1.
4. Full FIFO: enable=0, push 33 samples -> in_ready low after the 32nd; level=32; the 33rd value is not stored. Then enable=1 -> output 1..32 as two back-to-back frames (GAP=0) with no idle cycle between samples 16 and 17.
5. Gap insertion: GAP=3, push 32 samples -> frame 1, then exactly 3 idle cycles, then 1 IDLE evaluation cycle, then frame 2 with values 17..32.
6. Enable drop: deassert enable after the 5th sample of frame 1 with 32 samples queued -> frame 1 completes (16 samples) and no second frame starts; level=16. Reassert enable -> frame 2 emits 17..32.
